pipe_hazard_unit: RTL

- Parametrised hazard, forwarding and drain controller for the pipelined CPU; sits beside decode.
- Tracks every instruction in flight past decode in a DEPTH-entry scoreboard shift register.
- Produces per-operand forwarding selects, load-use stall, branch flush, halt-drain sequencing and occupancy.
- Replaces hard-wired 3-stage hazard logic; supports any post-decode depth and register-file size.

---
 rtl/pipe_hazard_unit.sv | 116 +++++++++++
 1 files changed

// File: rtl/pipe_hazard_unit.sv
// Hazard, forwarding and halt-drain controller beside decode. Forward selects and stall/flush are
// combinational off the scoreboard; occupancy and halted are registered. Stall holds PC and IF/ID.
module pipe_hazard_unit #(
  parameter int NUM_REGS    = 16,
  parameter int DEPTH       = 3,
  parameter int LOAD_STAGE  = 2,
  parameter int ZERO_REG_EN = 1,
  localparam int REG_W      = $clog2(NUM_REGS),
  localparam int SEL_W      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_reg_write,
  input  logic             id_is_load,
  input  logic             id_is_halt,
  input  logic             br_taken,
  output logic             stall,
  output logic             flush,
  output logic [SEL_W-1:0] fwd_rs_sel,
  output logic [SEL_W-1:0] fwd_rt_sel,
  output logic [SEL_W-1:0] in_flight_cnt,
  output logic             pipe_empty,
  output logic             halted
);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} state_t;

  state_t           state_q, state_d;
  logic [DEPTH:1]   vld_q, vld_d, rw_q, rw_d, ld_q, ld_d;
  logic [REG_W-1:0] rd_q [1:DEPTH];
  logic [REG_W-1:0] rd_d [1:DEPTH];
  logic             rs_ld_hit, rt_ld_hit, load_use, issue;
  logic             rs_zero, rt_zero;

  assign rs_zero = (ZERO_REG_EN != 0) && (id_rs == '0);
  assign rt_zero = (ZERO_REG_EN != 0) && (id_rt == '0);

  // Walk oldest to youngest so the youngest matching writer is left in the select.
  always_comb begin
    fwd_rs_sel = '0;
    fwd_rt_sel = '0;
    rs_ld_hit  = 1'b0;
    rt_ld_hit  = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (id_rs_used && !rs_zero && vld_q[k] && rw_q[k] && rd_q[k] == id_rs) begin
        fwd_rs_sel = SEL_W'(k);
        rs_ld_hit  = ld_q[k] && (k < LOAD_STAGE);
      end
      if (id_rt_used && !rt_zero && vld_q[k] && rw_q[k] && rd_q[k] == id_rt) begin
        fwd_rt_sel = SEL_W'(k);
        rt_ld_hit  = ld_q[k] && (k < LOAD_STAGE);
      end
    end
  end

  assign load_use = id_valid && (rs_ld_hit || rt_ld_hit);
  assign stall    = load_use || (state_q != ST_RUN);
  assign issue    = id_valid && !stall;
  assign flush    = br_taken && id_valid && !stall && !id_is_halt;

  always_comb begin
    vld_d    = '0;
    rw_d     = '0;
    ld_d     = '0;
    vld_d[1] = issue;
    rw_d[1]  = issue && id_reg_write && !id_is_halt;
    ld_d[1]  = issue && id_is_load;
    rd_d[1]  = id_rd;
    for (int k = 2; k <= DEPTH; k++) begin
      vld_d[k] = vld_q[k-1];
      rw_d[k]  = rw_q[k-1];
      ld_d[k]  = ld_q[k-1];
      rd_d[k]  = rd_q[k-1];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (issue && id_is_halt) state_d = ST_DRAIN;
      ST_DRAIN: if (vld_d == '0) state_d = ST_HALTED;
      default:  state_d = ST_HALTED;
    endcase
  end

  always_comb begin
    in_flight_cnt = '0;
    for (int k = 1; k <= DEPTH; k++) in_flight_cnt = in_flight_cnt + SEL_W'(vld_q[k]);
  end

  assign pipe_empty = (vld_q == '0);
  assign halted     = (state_q == ST_HALTED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      vld_q   <= '0;
      rw_q    <= '0;
      ld_q    <= '0;
      for (int k = 1; k <= DEPTH; k++) rd_q[k] <= '0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      rw_q    <= rw_d;
      ld_q    <= ld_d;
      for (int k = 1; k <= DEPTH; k++) rd_q[k] <= rd_d[k];
    end
  end

endmodule
